// File: rtl/lut_bank_pkg.sv
// Shared constants and helpers for the LUT bank controller.
// Segment encoding is active-low {g,f,e,d,c,b,a}.
package lut_bank_pkg;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Tick-sampled push-button debouncer emitting a single-cycle pulse on an accepted press.
// A press is only reported once the button has been seen released since reset.
module btn_debounce
    import lut_bank_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = clog2(DB_CYCLES);

    logic          stable;
    logic          armed;
    logic [CW-1:0] run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            armed  <= 1'b0;
            run    <= '0;
            pulse  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (tick) begin
                // A button held through reset stays unarmed until a released sample is seen.
                if (!btn_raw) begin
                    armed <= 1'b1;
                end
                if (btn_raw != stable) begin
                    if (run == CW'(DB_CYCLES - 1)) begin
                        stable <= btn_raw;
                        run    <= '0;
                        pulse  <= btn_raw & armed;
                    end else begin
                        run <= run + 1'b1;
                    end
                end else begin
                    run <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/lut_bank_ctrl.sv
// Board-level data-entry bank: stage a byte, commit it to the next slot, browse stored slots.
// Owns the debounce tick divider, bank storage, pointers and LED/7-seg outputs.
module lut_bank_ctrl
    import lut_bank_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              save_data,
    input  logic              show_reg,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              full,
    output logic              wr_err,
    output logic [6:0]        seg
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int TICK_W = clog2(SCAN_DIV);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              save_p;
    logic              write_p;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_next;
    logic [ADDR_W-1:0] rd_next;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] stage;
    logic              staged_valid;
    logic [3:0]        seg_idx;

    assign tick = (tick_cnt == TICK_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_save (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .btn_raw (save_data),
        .pulse   (save_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_write (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .btn_raw (write_en),
        .pulse   (write_p)
    );

    // DEPTH need not be a power of two, so wrap explicitly.
    assign wr_next = (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_next = (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            stage        <= '0;
            staged_valid <= 1'b0;
            d_out        <= '0;
            wr_err       <= 1'b0;
        end else begin
            wr_err <= 1'b0;
            d_out  <= show_reg ? mem[rd_ptr] : stage;
            if (!show_reg) begin
                if (write_p) begin
                    if (staged_valid) begin
                        mem[wr_ptr] <= stage;
                        wr_ptr      <= wr_next;
                        if (count != (ADDR_W + 1)'(DEPTH)) begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        wr_err <= 1'b1;
                    end
                end
                // A simultaneous save re-stages after the write consumed the old value.
                if (save_p) begin
                    stage        <= d_in;
                    staged_valid <= 1'b1;
                end else if (write_p) begin
                    staged_valid <= 1'b0;
                end
            end else if (save_p) begin
                rd_ptr <= rd_next;
            end
        end
    end

    assign full    = (count == (ADDR_W + 1)'(DEPTH));
    assign seg_idx = show_reg ? 4'(rd_ptr) : 4'(wr_ptr);
    assign seg     = rst ? 7'b0000000 : SEG_HEX[seg_idx];

endmodule

// File: tb/tb_lut_bank_ctrl.sv
// Self-checking bench for lut_bank_ctrl: directed operator scenarios plus randomized
// button/mode activity, compared every cycle against a behavioural model of the bank.
module tb_lut_bank_ctrl;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int SCAN_DIV = 2;
    localparam int DB       = 4;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              write_en  = 1'b0;
    logic              save_data = 1'b0;
    logic              show_reg  = 1'b0;
    logic [DATA_W-1:0] d_in      = '0;
    logic [DATA_W-1:0] d_out;
    logic              full;
    logic              wr_err;
    logic [6:0]        seg;

    always #5 clk = ~clk;

    lut_bank_ctrl #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write_en  (write_en),
        .save_data (save_data),
        .show_reg  (show_reg),
        .d_in      (d_in),
        .d_out     (d_out),
        .full      (full),
        .wr_err    (wr_err),
        .seg       (seg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Behavioural model: bank as an array, debounce as a sample history window.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_wr, m_rd, m_count, m_n;
    logic [DATA_W-1:0] m_stage, m_dout;
    bit                m_sv, m_err;
    bit                m_pulse [2];
    logic [DB-1:0]     m_hist [2];
    bit                m_stable [2];
    bit                m_seen_low [2];
    int                seen_save = 0;
    int                seen_err  = 0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_wr = 0; m_rd = 0; m_count = 0; m_n = 0;
        m_stage = '0; m_dout = '0; m_sv = 0; m_err = 0;
        for (int b = 0; b < 2; b++) begin
            m_pulse[b] = 0; m_hist[b] = '0; m_stable[b] = 0; m_seen_low[b] = 0;
        end
    endtask

    task automatic db_sample(input int b, input bit raw, output bit p);
        p = 0;
        m_hist[b] = {m_hist[b][DB-2:0], raw};
        if (m_hist[b] == {DB{~m_stable[b]}}) begin
            m_stable[b] = ~m_stable[b];
            p = m_stable[b] && m_seen_low[b];
        end
        if (!raw) m_seen_low[b] = 1;
    endtask

    task automatic model_edge();
        bit sp, wp, old_sv, tk;
        logic [DATA_W-1:0] next_dout;
        if (rst) begin
            model_reset();
            return;
        end
        sp = m_pulse[0];
        wp = m_pulse[1];
        old_sv = m_sv;
        next_dout = show_reg ? m_mem[m_rd] : m_stage;
        m_err = 0;
        if (!show_reg) begin
            if (wp) begin
                if (old_sv) begin
                    m_mem[m_wr] = m_stage;
                    m_wr = (m_wr + 1) % DEPTH;
                    if (m_count < DEPTH) m_count++;
                end else begin
                    m_err = 1;
                end
            end
            if (sp) begin
                m_stage = d_in;
                m_sv = 1;
            end else if (wp && old_sv) begin
                m_sv = 0;
            end
        end else if (sp) begin
            m_rd = (m_rd + 1) % DEPTH;
        end
        m_dout = next_dout;
        tk = (m_n % SCAN_DIV) == SCAN_DIV - 1;
        if (tk) begin
            db_sample(0, save_data, m_pulse[0]);
            db_sample(1, write_en, m_pulse[1]);
        end else begin
            m_pulse[0] = 0;
            m_pulse[1] = 0;
        end
        m_n++;
    endtask

    task automatic check_all();
        chk("d_out", 32'(d_out), 32'(m_dout));
        chk("full", 32'(full), 32'(m_count == DEPTH));
        chk("wr_err", 32'(wr_err), 32'(m_err));
        chk("seg", 32'(seg), rst ? 32'd0 : 32'(seg_ref[show_reg ? m_rd : m_wr]));
        chk("save_p", 32'(dut.u_db_save.pulse), 32'(m_pulse[0]));
        chk("write_p", 32'(dut.u_db_write.pulse), 32'(m_pulse[1]));
        seen_save += int'(dut.u_db_save.pulse);
        seen_err  += int'(wr_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic ticks(input int n);
        run(n * SCAN_DIV);
    endtask

    task automatic press(input bit is_write);
        if (is_write) write_en = 1'b1; else save_data = 1'b1;
        ticks(DB + 1);
        if (is_write) write_en = 1'b0; else save_data = 1'b0;
        ticks(DB + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        run(2);
        rst = 1'b0;
        #1;
        check_all();
    endtask

    logic [DATA_W-1:0] fill_vals [4]   = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DATA_W-1:0] browse_vals [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h22};
    int s0, e0;

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        #1;
        chk("seg_after_release", 32'(seg), 32'h40);
        run(4);

        // Bounce then hold on save
        s0 = seen_save;
        save_data = 1'b1; ticks(1);
        save_data = 1'b0; ticks(1);
        chk("no_pulse_bouncing", seen_save - s0, 0);
        save_data = 1'b1; ticks(1);
        ticks(DB + 1);
        chk("one_pulse_after_hold", seen_save - s0, 1);
        save_data = 1'b0;
        ticks(DB + 1);

        // Entry of A5
        do_reset();
        run(4);
        d_in = 8'hA5;
        press(0);
        chk("entry_dout", 32'(d_out), 32'hA5);
        chk("entry_seg0", 32'(seg), 32'h40);
        press(1);
        chk("entry_seg1", 32'(seg), 32'h79);
        show_reg = 1'b1; run(2);
        chk("entry_mem0", 32'(d_out), 32'hA5);
        show_reg = 1'b0; run(2);

        // Write without a staged value
        do_reset();
        run(4);
        e0 = seen_err;
        press(1);
        chk("err_pulses", seen_err - e0, 1);
        chk("err_seg", 32'(seg), 32'h40);
        show_reg = 1'b1; run(2);
        chk("err_bank_clear", 32'(d_out), 32'h0);
        show_reg = 1'b0; run(2);

        // Fill and overwrite oldest
        for (int i = 0; i < 4; i++) begin
            d_in = fill_vals[i];
            press(0);
            press(1);
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_seg_wrap", 32'(seg), 32'h40);
        d_in = 8'h55;
        press(0);
        press(1);
        chk("overwrite_seg", 32'(seg), 32'h79);
        chk("overwrite_full", 32'(full), 32'h1);

        // Browse with rd_ptr wrap
        show_reg = 1'b1;
        run(2);
        chk("browse_slot0", 32'(d_out), 32'h55);
        for (int i = 0; i < 5; i++) begin
            press(0);
            chk("browse_step", 32'(d_out), 32'(browse_vals[i]));
        end
        show_reg = 1'b0;
        run(2);

        // Reset with save held and a valid stage
        d_in = 8'h3C;
        save_data = 1'b1;
        ticks(DB + 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_d_out", 32'(d_out), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);
        run(2);
        rst = 1'b0;
        s0 = seen_save;
        ticks(3 * DB);
        chk("no_pulse_held_thru_rst", seen_save - s0, 0);
        save_data = 1'b0;
        ticks(DB + 1);
        press(0);
        chk("pulse_after_repress", seen_save - s0, 1);
        chk("repress_dout", 32'(d_out), 32'h3C);

        // Randomized activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) save_data = ~save_data;
            if ($urandom_range(0, 3) == 0) write_en  = ~write_en;
            if ($urandom_range(0, 15) == 0) show_reg = ~show_reg;
            d_in = DATA_W'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            ticks(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
